booth_pp_accum: RTL
===================

// Module: booth_pp_accum
// PURPOSE
//  Sequential radix-4 Booth multiplier core. Consumer side of the boothcode partial-product interface.
//  Accepts signed A x B through a start/ready handshake and drives A plus one 3-bit Booth code per cycle to
//  an external boothcode instance. It takes back {product,h,s} in the same cycle, accumulates the weighted
//  partial products and returns a signed 64-bit product.
//  Sits between the multiplier front-end (operand issue) and the result writeback.
// PARAMETERS
//  W      32     operand width. Must be even and must match the boothcode width (pp_i is W+1 bits).
//  NSTEP  W/2    Booth digits per operation (local, derived; not overridable).
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     request; accepted when start && ready at a clk edge
//  ready      out  1     high when not RUN (IDLE or DONE)
//  a_i        in   W     multiplicand, signed; sampled at accept
//  b_i        in   W     multiplier, signed; sampled at accept
//  pp_a_o     out  W     latched A, drives boothcode.A
//  code_o     out  3     current Booth triplet, drives boothcode.code
//  pp_i       in   W+1   boothcode.product (same-cycle combinational return)
//  h_i        in   2     boothcode.h; +1 correction for negative digits
//  s_i        in   1     boothcode.s; inverted sign of pp_i
//  done       out  1     one-cycle pulse; product_o is valid
//  product_o  out  2W    signed A*B; held until the next accepted start
//  pp_err     out  1     sticky protocol error; cleared on accept
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE.
//   - ready=1; done=0; pp_err=0.
//   - product_o=0, pp_a_o=0, code_o=0, internal accumulator/counter/shift reg =0.
//  Reset asserted mid-operation aborts the operation; no done is issued.
//  FSM states:
//   - IDLE: on accept -> RUN.
//   - RUN: counter i=0..NSTEP-1, one digit per cycle; at i=NSTEP-1 -> DONE.
//   - DONE: 1 cycle, done=1; -> RUN if accept this cycle, else -> IDLE.
//  Accept actions:
//   - pp_a_o<=a_i; breg<={b_i,1'b0} (W+1 bits); acc<=0; i<=0; pp_err<=0.
//  In RUN:
//   - code_o=breg[2:0]; breg shifts right 2 per cycle, filling with the sign bit b_i[W-1].
//   - Digit i uses B bits {b[2i+1],b[2i],b[2i-1]}, with b[-1]=0.
//  Accumulation, each RUN cycle, modulo 2^(2W):
//   - acc <= acc + ((sext_2W(pp_i) + h_i) << 2i).
//   - sext uses pp_i[W] as sign.
//   - h_i is a 2-bit unsigned value (legal values 0/1).
//  Protocol check: in RUN, pp_err is set if pp_i[W] != ~s_i or h_i==2'b1x. Accumulation proceeds regardless.
//  Latency: accept at edge k -> RUN for edges k+1..k+NSTEP -> done=1 during the cycle after edge k+NSTEP.
//   - For W=32: start to done is 17 cycles.
//  product_o is loaded with the final acc in the same cycle that done rises.
//   - It is not disturbed by a new accept until that operation's done.
//  code_o and pp_a_o are don't-care outside RUN. They hold their last values; no toggling is required.
//  Boundaries:
//   - start while RUN: ignored (ready=0); no queueing.
//   - start in the DONE cycle: accepted back-to-back. done still pulses for the finished op.
//   - Most-negative operands: the modulo-2^(2W) result is exact.
//   - start held continuously: consecutive ops every NSTEP+1 cycles.
// TESTING (bench instantiates boothcode on pp_a_o/code_o -> pp_i/h_i/s_i)
//  1. A=3, B=5 -> done at start+17 cycles, product_o=64'd15, pp_err=0.
//  2. A=-1, B=-1 -> product_o=64'h0000_0000_0000_0001.
//  3. A=32'h8000_0000, B=32'h8000_0000 -> product_o=64'h4000_0000_0000_0000.
//  4. A=32'h7FFF_FFFF, B=32'h8000_0000 -> product_o=64'hC000_0000_8000_0000.
//  5. Start pulses during RUN -> ignored, single done. Start on DONE cycle -> back-to-back result correct.
//  6. rst_n low at RUN step 7 -> outputs zero immediately, no done. Next op A=7,B=-6 -> product_o=-42.
//  7. Force s_i=pp_i[W] for one cycle (bench override) -> pp_err=1 until next accept.
//  8. 10k random signed pairs, back-to-back -> product_o == $signed(A)*$signed(B) every done.

Source files
------------

// File: rtl/booth_pp_accum.sv
// booth_pp_accum: sequential radix-4 Booth multiplier that consumes external boothcode partial products
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start, ready       accept handshake; ready is high whenever no operation is running
//   a_i, b_i           signed operands, sampled at accept
//   pp_a_o, code_o     latched multiplicand and current Booth triplet, to boothcode
//   pp_i, h_i, s_i     boothcode partial product, negation correction and inverted sign
//   done               one-cycle pulse, product_o valid
//   product_o          signed 2W-bit product, held until the next operation completes
//   pp_err             sticky partial-product protocol error, cleared on accept
module booth_pp_accum #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           ready,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   pp_a_o,
    output logic [2:0]     code_o,
    input  logic [W:0]     pp_i,
    input  logic [1:0]     h_i,
    input  logic           s_i,
    output logic           done,
    output logic [2*W-1:0] product_o,
    output logic           pp_err
);
    localparam int NSTEP = W / 2;
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   pp_a_q, pp_a_d;
    logic [W:0]     breg_q, breg_d;
    logic [2*W-1:0] acc_q, acc_d, prod_q, prod_d, addend;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d, run, accept, last;

    assign run       = state_q == S_RUN;
    assign ready     = !run;
    assign accept    = start && ready;
    assign last      = cnt_q == CW'(NSTEP - 1);
    assign done      = state_q == S_DONE;
    assign pp_a_o    = pp_a_q;
    assign code_o    = breg_q[2:0];
    assign product_o = prod_q;
    assign pp_err    = err_q;

    // weighted partial product: sign-extended pp plus the +1 that completes negation, at digit weight 4^i
    assign addend = ({{(W-1){pp_i[W]}}, pp_i} + {{(2*W-2){1'b0}}, h_i}) << {cnt_q, 1'b0};

    always_comb begin
        state_d = state_q;
        pp_a_d  = pp_a_q;
        breg_d  = breg_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (run) begin
            acc_d   = acc_q + addend;
            // breg top bit is b[W-1], so replicating it sign-extends the multiplier
            breg_d  = {breg_q[W], breg_q[W], breg_q[W:2]};
            cnt_d   = cnt_q + 1'b1;
            err_d   = err_q | (pp_i[W] == s_i) | h_i[1];
            state_d = last ? S_DONE : S_RUN;
            prod_d  = last ? acc_q + addend : prod_q;
        end else begin
            state_d = accept ? S_RUN : S_IDLE;
        end
        if (accept) begin
            pp_a_d = a_i;
            breg_d = {b_i, 1'b0};
            acc_d  = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pp_a_q  <= '0;
            breg_q  <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pp_a_q  <= pp_a_d;
            breg_q  <= breg_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule
